// File: rtl/tb_pkg.sv
// Shared constants, snoop FSM state type and the little-endian to readable byte swap
// used by the test port snooper.
package tb_pkg;

  localparam logic [29:0] TEST_PORT = 30'hFF;
  localparam logic [31:0] BEGIN_SYM = 32'h0000_0168;
  localparam logic [31:0] END_SYM   = 32'hFFFF_FD5D;

  typedef enum logic {IDLE, HELD} snoop_state_t;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a pop in the same cycle frees a slot
// so a push into a full FIFO is accepted when it coincides with a pop.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/test_port_snooper.sv
// Snoops the data-memory write bus, captures each distinct store to the test port
// exactly once (stall repeats suppressed), byte-swaps it and queues it for the checker.
module test_port_snooper #(
  parameter logic [29:0] TEST_PORT = tb_pkg::TEST_PORT,
  parameter logic [31:0] BEGIN_SYM = tb_pkg::BEGIN_SYM,
  parameter logic [31:0] END_SYM   = tb_pkg::END_SYM,
  parameter int          DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_wen,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        seen_begin,
  output logic        seen_end,
  output logic        overflow,
  output logic [7:0]  store_count
);

  tb_pkg::snoop_state_t state;
  tb_pkg::snoop_state_t state_nxt;

  logic [29:0] last_addr;
  logic [31:0] last_data;
  logic        new_store;
  logic        capture;
  logic [31:0] swapped;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= tb_pkg::IDLE;
    else      state <= state_nxt;
  end

  // A held store only counts as new once its address or data changes.
  always_comb begin
    state_nxt = state;
    new_store = 1'b0;
    case (state)
      tb_pkg::IDLE: begin
        if (mem_wen) begin
          new_store = 1'b1;
          state_nxt = tb_pkg::HELD;
        end
      end
      tb_pkg::HELD: begin
        if (!mem_wen) state_nxt = tb_pkg::IDLE;
        else          new_store = (mem_addr != last_addr) || (mem_wdata != last_data);
      end
      default: state_nxt = tb_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (new_store) begin
      last_addr <= mem_addr;
      last_data <= mem_wdata;
    end
  end

  assign capture   = new_store && (mem_addr == TEST_PORT);
  assign swapped   = tb_pkg::byte_swap(mem_wdata);
  assign pop       = out_ready && !fifo_empty;
  assign out_valid = !fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seen_begin  <= 1'b0;
      seen_end    <= 1'b0;
      overflow    <= 1'b0;
      store_count <= '0;
    end else if (capture) begin
      if (swapped == BEGIN_SYM)  seen_begin  <= 1'b1;
      if (swapped == END_SYM)    seen_end    <= 1'b1;
      if (fifo_full && !pop)     overflow    <= 1'b1;
      if (store_count != 8'hFF)  store_count <= store_count + 8'd1;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .wdata (swapped),
    .full  (fifo_full),
    .pop   (pop),
    .rdata (out_data),
    .empty (fifo_empty)
  );

endmodule
